// File: rtl/upload_arbiter.sv
// Merges NUM_SRC byte upload ports into one output stream. Packets hold the grant until
// their request drops. Streams give way to packets at a byte boundary, and to other
// waiting sources after STREAM_BURST bytes.
module upload_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned STREAM_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [8*NUM_SRC-1:0] src_source,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic                 fifo_almost_full,
  output logic [7:0]           out_data,
  output logic [7:0]           out_source,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic [2:0]           grant_idx,
  output logic                 busy
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(STREAM_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STREAM_BURST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PKT    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [IDX_W-1:0]   w_win;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               r_sop_pend, w_sop_nxt;
  logic               r_out_valid, r_out_sop;
  logic [7:0]         r_out_data, r_out_source;
  logic [NUM_SRC-1:0] w_cand, w_onehot;
  logic               w_win_ok, w_active, w_xfer, w_other_req, w_other_any;
  logic [7:0]         w_data, w_source;

  assign w_active    = (r_state != S_IDLE);
  assign w_onehot    = NUM_SRC'(1) << r_grant;
  assign src_ready   = (w_active && !fifo_almost_full) ? w_onehot : '0;
  assign w_xfer      = |(src_valid & src_ready);
  assign w_other_req = |(src_req & ~w_onehot);
  assign w_other_any = |((src_req | src_valid) & ~w_onehot);
  assign w_cand      = (|src_req) ? src_req : src_valid;
  assign w_cnt_inc   = (w_xfer && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

  // Round-robin: the winner is the candidate closest after last_grant.
  always_comb begin : arb
    int unsigned v_dist;
    int unsigned v_best;
    v_dist   = 0;
    v_best   = NUM_SRC;
    w_win    = '0;
    w_win_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      v_dist = (i + 2 * NUM_SRC - 1 - 32'(r_last)) % NUM_SRC;
      if (w_cand[i] && (v_dist < v_best)) begin
        v_best   = v_dist;
        w_win    = IDX_W'(i);
        w_win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    w_data   = '0;
    w_source = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_data   = src_data[8*i +: 8];
        w_source = src_source[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_sop_nxt   = r_sop_pend && !w_xfer;
    case (r_state)
      S_IDLE: begin
        if (w_win_ok) begin
          w_grant_nxt = w_win;
          w_sop_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = src_req[w_win] ? S_PKT : S_STREAM;
        end
      end
      S_PKT: begin
        if (!fifo_almost_full && !src_req[r_grant]) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
          w_grant_nxt = '0;
        end
      end
      S_STREAM: begin
        // Backpressure freezes the stream, so nothing changes while it is asserted.
        if (!fifo_almost_full) begin
          w_cnt_nxt = w_cnt_inc;
          if (src_req[r_grant]) begin
            w_state_nxt = S_PKT;
          end else if (!src_valid[r_grant] || w_other_req ||
                       ((w_cnt_inc == CNT_MAX) && w_other_any)) begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = r_grant;
            w_grant_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last       <= IDX_W'(NUM_SRC - 1);
      r_cnt        <= '0;
      r_sop_pend   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_data   <= '0;
      r_out_source <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sop_pend  <= w_sop_nxt;
      r_out_valid <= w_xfer;
      r_out_sop   <= w_xfer && r_sop_pend;
      if (w_xfer) begin
        r_out_data   <= w_data;
        r_out_source <= w_source;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_source = r_out_source;
  assign out_valid  = r_out_valid;
  assign out_sop    = r_out_sop;
  assign grant_idx  = 3'(r_grant);
  assign busy       = w_active;

endmodule

// File: tb/tb_upload_arbiter.sv
// Bench for upload_arbiter: directed scenarios and random traffic, all compared cycle by
// cycle against a transaction-level reference model.
module tb_upload_arbiter;
  localparam int N     = 4;
  localparam int BURST = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req, src_valid, src_ready;
  logic [8*N-1:0] src_data, src_source;
  logic           fifo_almost_full;
  logic [7:0]     out_data, out_source;
  logic           out_valid, out_sop;
  logic [2:0]     grant_idx;
  logic           busy;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SRC(N), .STREAM_BURST(BURST)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_valid(src_valid),
    .src_data(src_data), .src_source(src_source), .src_ready(src_ready),
    .fifo_almost_full(fifo_almost_full), .out_data(out_data),
    .out_source(out_source), .out_valid(out_valid), .out_sop(out_sop),
    .grant_idx(grant_idx), .busy(busy)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: granted source, lock kind, bytes sent in this grant, expected outputs.
  bit         m_active, m_pkt, m_sop;
  int         m_g, m_last, m_cnt;
  bit         e_valid, e_sop;
  logic [7:0] e_data, e_src;

  bit         track;
  int         run_len;
  logic [7:0] run_src;

  task automatic model_reset();
    m_active = 0; m_pkt = 0; m_sop = 0;
    m_g = 0; m_last = N - 1; m_cnt = 0;
    e_valid = 0; e_sop = 0; e_data = 8'h00; e_src = 8'h00;
  endtask

  task automatic model_release();
    m_active = 0;
    m_last   = m_g;
    m_g      = 0;
  endtask

  function automatic logic [7:0] byte_of(input logic [8*N-1:0] v, input int i);
    return v[8*i +: 8];
  endfunction

  task automatic model_step();
    bit xfer, other_req, other_any, anyreq;
    int pick;
    if (rst) begin
      model_reset();
      return;
    end
    xfer    = m_active && !fifo_almost_full && src_valid[m_g];
    e_valid = xfer;
    e_sop   = xfer && m_sop;
    if (xfer) begin
      e_data = byte_of(src_data, m_g);
      e_src  = byte_of(src_source, m_g);
      m_sop  = 0;
    end
    if (!m_active) begin
      anyreq = |src_req;
      pick   = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (pick < 0 && (anyreq ? src_req[idx] : src_valid[idx])) pick = idx;
      end
      if (pick >= 0) begin
        m_active = 1; m_g = pick; m_pkt = src_req[pick]; m_cnt = 0; m_sop = 1;
      end
    end else if (!fifo_almost_full) begin
      other_req = 0;
      other_any = 0;
      for (int i = 0; i < N; i++) begin
        if (i != m_g) begin
          other_req |= src_req[i];
          other_any |= src_req[i] | src_valid[i];
        end
      end
      if (m_pkt) begin
        if (!src_req[m_g]) model_release();
      end else begin
        if (xfer && m_cnt < BURST) m_cnt++;
        if (src_req[m_g]) m_pkt = 1;
        else if (!src_valid[m_g] || other_req || (m_cnt == BURST && other_any)) model_release();
      end
    end
  endtask

  task automatic run_cycle(input logic [N-1:0] req, input logic [N-1:0] val,
                           input logic af, input logic r);
    logic [N-1:0] exp_ready;
    @(negedge clk);
    src_req = req; src_valid = val; fifo_almost_full = af; rst = r;
    src_data = 32'($urandom);
    #1;
    exp_ready = (m_active && !af) ? (N'(1) << m_g) : '0;
    if (!r) chk("src_ready", 32'(src_ready), 32'(exp_ready));
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_sop", 32'(out_sop), 32'(e_sop));
    chk("grant_idx", 32'(grant_idx), 32'(m_g));
    chk("busy", 32'(busy), 32'(m_active));
    if (e_valid || r) begin
      chk("out_data", 32'(out_data), 32'(e_data));
      chk("out_source", 32'(out_source), 32'(e_src));
    end
    if (track && out_valid) begin
      if (out_sop) begin
        if (run_len > 0) begin
          chk("burst_len", 32'(run_len), 32'(BURST));
          chk("burst_alt", 32'(out_source), (run_src == 8'h1B) ? 32'h3B : 32'h1B);
        end
        run_src = out_source;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
  endtask

  initial begin
    logic [N-1:0] rq, vv;
    logic         aa, rr;
    src_req = '0; src_valid = '0; src_data = '0; fifo_almost_full = 1'b0; rst = 1'b1;
    src_source = {8'h3B, 8'h2B, 8'h1B, 8'h0B};
    track = 0; run_len = 0; run_src = 8'h00;
    model_reset();

    repeat (2) run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    // Single stream from source 0.
    repeat (20) run_cycle(4'b0000, 4'b0001, 1'b0, 1'b0);
    // Packet from source 2 preempts the stream, then source 0 resumes.
    repeat (6) run_cycle(4'b0100, 4'b0101, 1'b0, 1'b0);
    repeat (6) run_cycle(4'b0000, 4'b0001, 1'b0, 1'b0);

    // Two continuous streams share the output in BURST-byte turns.
    run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    track = 1; run_len = 0;
    repeat (40) run_cycle(4'b0000, 4'b1010, 1'b0, 1'b0);
    track = 0;

    // Backpressure in the middle of a packet on source 1.
    repeat (4) run_cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    repeat (10) run_cycle(4'b0010, 4'b0011, 1'b1, 1'b0);
    repeat (4) run_cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);

    // All four request 3-byte packets: grants rotate 0,1,2,3,0.
    run_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    rq = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      run_cycle(rq, 4'b1111, 1'b0, 1'b0);
      chk("rr_order", 32'(grant_idx), 32'(p % N));
      repeat (2) run_cycle(rq, 4'b1111, 1'b0, 1'b0);
      run_cycle(rq & ~(N'(1) << (p % N)), 4'b1111, 1'b0, 1'b0);
    end

    // Reset in the middle of a packet on source 1.
    repeat (3) run_cycle(4'b0010, 4'b0011, 1'b0, 1'b0);
    run_cycle(4'b0011, 4'b0011, 1'b0, 1'b1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    run_cycle(4'b0011, 4'b0011, 1'b0, 1'b0);
    chk("post_rst_grant", 32'(grant_idx), 32'd0);

    // Random traffic with sticky requests and backpressure bursts.
    rq = '0; aa = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          if ($urandom_range(0, 5) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          rq[i] = 1'b1;
        end
      end
      vv = N'($urandom) | N'($urandom);
      if (aa) aa = ($urandom_range(0, 2) != 0);
      else    aa = ($urandom_range(0, 11) == 0);
      rr = ($urandom_range(0, 499) == 0);
      run_cycle(rq, vv, aa, rr);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
